// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, FSM state encoding and opcode
//               classification helpers for the bit-serial ALU controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode encodings as presented on ALU_control.
  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_slt  = 4'b0111;
  localparam logic [3:0] c_op_nor  = 4'b1100;
  localparam logic [3:0] c_op_nand = 4'b1101;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Opcodes that run the slice as src1 + ~src2 + 1.
  function automatic logic op_is_sub(input logic [3:0] op);
    return (op == c_op_sub) || (op == c_op_slt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_bit_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu_bit_slice
// Description : Purely combinational one-bit ALU slice.
//   a, b  : operand bits
//   cin   : carry in (registered by the caller between bits)
//   op    : 4-bit opcode
//   r     : result bit
//   co    : carry out (0 for non-arithmetic opcodes, keeping the carry chain
//           idle for logic operations)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] op,
  output logic       r,
  output logic       co
);

  logic w_b_eff;

  // Subtraction-style opcodes feed the inverted B bit into the adder.
  assign w_b_eff = op_is_sub(op) ? ~b : b;

  always_comb begin
    r  = 1'b0;
    co = 1'b0;
    case (op)
      c_op_and:  r = a & b;
      c_op_or:   r = a | b;
      c_op_nor:  r = ~(a | b);
      c_op_nand: r = ~(a & b);
      c_op_add, c_op_sub, c_op_slt: begin
        r  = a ^ w_b_eff ^ cin;
        co = (a & w_b_eff) | (a & cin) | (w_b_eff & cin);
      end
      default: begin
        r  = 1'b0;
        co = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial ALU. Operands are captured on start&ready, then one
//               bit per cycle is computed LSB first through alu_bit_slice with
//               a registered carry. Flags and result are published on entry
//               to DONE and held until the next completion or reset.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : request, sampled only while ready
//   src1, src2           : operands (WIDTH bits)
//   ALU_control          : opcode
//   ready                : idle and able to accept start
//   done                 : one-cycle completion pulse
//   result, zero, cout,
//   overflow             : registered result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cin_msb;
  // Set once the MSB has been processed; the following RUN cycle publishes
  // the result, which places done WIDTH+1 cycles after acceptance.
  logic             r_fin;

  logic             w_accept;
  logic             w_bit_r;
  logic             w_bit_co;
  logic             w_arith_ovf;
  logic [WIDTH-1:0] w_final_res;
  logic             w_final_cout;
  logic             w_final_ovf;

  assign ready    = (r_state == ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign w_accept = ready && start;

  alu_bit_slice u_slice (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .op  (r_op),
    .r   (w_bit_r),
    .co  (w_bit_co)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN:  if (r_fin) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------- finalisation
  // Signed overflow is the carry into the MSB disagreeing with the carry out.
  assign w_arith_ovf = r_cin_msb ^ r_carry;

  always_comb begin
    w_final_res  = '0;
    w_final_cout = 1'b0;
    w_final_ovf  = 1'b0;
    case (r_op)
      c_op_add, c_op_sub: begin
        w_final_res  = r_acc;
        w_final_cout = r_carry;
        w_final_ovf  = w_arith_ovf;
      end
      c_op_slt: begin
        // True sign of src1-src2 is the difference MSB corrected by overflow.
        w_final_res  = {{(WIDTH-1){1'b0}}, r_acc[WIDTH-1] ^ w_arith_ovf};
        w_final_cout = r_carry;
      end
      c_op_and, c_op_or, c_op_nor, c_op_nand: begin
        w_final_res = r_acc;
      end
      default: begin
        w_final_res = '0;
      end
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_cin_msb <= 1'b0;
      r_fin     <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a       <= src1;
        r_b       <= src2;
        r_op      <= ALU_control;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_carry   <= op_is_sub(ALU_control);
        r_cin_msb <= 1'b0;
        r_fin     <= 1'b0;
      end else if (r_state == ST_RUN) begin
        if (!r_fin) begin
          // Result bits enter at the top so the LSB lands at bit 0 last.
          r_acc   <= {w_bit_r, r_acc[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_bit_co;
          if (r_cnt == c_last) begin
            r_cin_msb <= r_carry;
            r_fin     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          result   <= w_final_res;
          zero     <= (w_final_res == '0);
          cout     <= w_final_cout;
          overflow <= w_final_ovf;
          r_fin    <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_ctrl
// Description : Self-checking bench for alu_serial_ctrl (WIDTH=32). Expected
//               values come from a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] src1 = '0;
  logic [WIDTH-1:0] src2 = '0;
  logic [3:0]       ALU_control = '0;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .ready       (ready),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .cout        (cout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: signed/unsigned arithmetic on 32-bit values.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output logic [31:0] res, output logic co, output logic ov);
    logic [32:0] s;
    res = '0; co = 1'b0; ov = 1'b0;
    case (op)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b1100: res = ~(a | b);
      4'b1101: res = ~(a & b);
      4'b0010: begin
        s   = {1'b0, a} + {1'b0, b};
        res = s[31:0];
        co  = s[32];
        ov  = ($signed(a) + $signed(b)) != ($signed({a[31], a}) + $signed({b[31], b}));
        ov  = (a[31] == b[31]) && (res[31] != a[31]);
      end
      4'b0110: begin
        res = a - b;
        co  = (a >= b);
        ov  = (a[31] != b[31]) && (res[31] != a[31]);
      end
      4'b0111: begin
        res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        co  = (a >= b);
      end
      default: res = '0;
    endcase
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op);
    logic [31:0] er; logic ec; logic eo;
    model(a, b, op, er, ec, eo);
    chk({tag, ".result"},   64'(result),   64'(er));
    chk({tag, ".zero"},     64'(zero),     64'(er == 32'd0));
    chk({tag, ".cout"},     64'(cout),     64'(ec));
    chk({tag, ".overflow"}, 64'(overflow), 64'(eo));
  endtask

  // Drive start with operands until an edge accepts them, then scramble inputs.
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int n;
    n = 0;
    while (!ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("ready_before_start", 64'(ready), 64'd1);
    @(negedge clk);
    start = 1'b1; src1 = a; src2 = b; ALU_control = op;
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
    chk("busy_after_accept", 64'(ready), 64'd0);
  endtask

  // Counts edges after acceptance until done is seen; optionally injects a
  // start pulse with fresh operands at a given edge number.
  task automatic wait_done(input int inject_at, output int n);
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 200) begin
      @(posedge clk); #1; n++;
      if (n == inject_at) begin
        start = 1'b1; src1 = $urandom; src2 = $urandom; ALU_control = 4'b0010;
      end else if (n == inject_at + 1) begin
        start = 1'b0;
      end
      if (done) seen = 1;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input int inject_at);
    int n;
    accept(a, b, op);
    wait_done(inject_at, n);
    chk({tag, ".latency"}, 64'(n), 64'(WIDTH + 1));
    check_result(tag, a, b, op);
    @(posedge clk); #1;
    chk({tag, ".single_done"}, 64'(done), 64'd0);
    chk({tag, ".ready_after"}, 64'(ready), 64'd1);
    check_result({tag, ".hold"}, a, b, op);
  endtask

  initial begin : main
    logic [3:0]  ops [9];
    logic [31:0] a2, b2;
    int n;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b0011, 4'b1111};

    // Reset state.
    #12;
    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.flags", 64'({zero, cout, overflow}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed corner cases.
    run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, -1);
    chk("add_ovf.exact", 64'({result, overflow, cout, zero}), 64'({32'h8000_0000, 3'b100}));
    run_op("sub_eq",   32'h0000_0005, 32'h0000_0005, 4'b0110, -1);
    chk("sub_eq.exact", 64'({result, zero, cout, overflow}), 64'({32'h0, 3'b110}));
    run_op("slt_neg",  32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, -1);
    chk("slt_neg.exact", 64'(result), 64'd1);
    run_op("slt_pos",  32'h0000_0001, 32'hFFFF_FFFF, 4'b0111, -1);
    chk("slt_pos.exact", 64'(result), 64'd0);
    run_op("nor0",     32'h0, 32'h0, 4'b1100, -1);
    chk("nor0.exact", 64'({result, zero}), 64'({32'hFFFF_FFFF, 1'b0}));
    run_op("nand1",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1101, -1);
    chk("nand1.exact", 64'({result, zero}), 64'({32'h0, 1'b1}));
    run_op("undef",    32'h1234_5678, 32'h0F0F_0F0F, 4'b1010, -1);
    chk("undef.exact", 64'({result, zero, cout, overflow}), 64'({32'h0, 3'b100}));
    run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 4'b0110, -1);
    run_op("slt_ovf",  32'h8000_0000, 32'h0000_0001, 4'b0111, -1);

    // Start while busy is ignored.
    run_op("busy_start", 32'h0000_1111, 32'h0000_2222, 4'b0010, 10);

    // Start in DONE is ignored, start in the following IDLE is accepted.
    accept(32'hDEAD_BEEF, 32'h1234_5678, 4'b0001);
    wait_done(-1, n);
    chk("b2b.first_latency", 64'(n), 64'(WIDTH + 1));
    check_result("b2b.first", 32'hDEAD_BEEF, 32'h1234_5678, 4'b0001);
    a2 = 32'h0000_0009; b2 = 32'h0000_000C;
    start = 1'b1; src1 = a2; src2 = b2; ALU_control = 4'b0110;
    @(posedge clk); #1;
    chk("b2b.ignored_in_done", 64'(ready), 64'd1);
    @(posedge clk); #1;
    chk("b2b.accepted_in_idle", 64'(ready), 64'd0);
    start = 1'b0; src1 = $urandom; src2 = $urandom;
    wait_done(-1, n);
    chk("b2b.second_latency", 64'(n), 64'(WIDTH + 1));
    check_result("b2b.second", a2, b2, 4'b0110);
    @(posedge clk); #1;

    // Reset during RUN abandons the operation.
    accept(32'h0000_0100, 32'h0000_0001, 4'b0110);
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstrun.ready", 64'(ready), 64'd1);
    chk("rstrun.done", 64'(done), 64'd0);
    chk("rstrun.result", 64'(result), 64'd0);
    chk("rstrun.flags", 64'({zero, cout, overflow}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("rstrun.no_done", 64'(n), 64'd0);
    run_op("post_rst_add", 32'd2, 32'd3, 4'b0010, -1);
    chk("post_rst_add.exact", 64'(result), 64'd5);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 6 == 0) rb = ra;
      run_op("rand", ra, rb, ops[$urandom_range(0, 8)], -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal values 2..64).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  request to begin an operation; sampled only when ready=1.
REQ-005 Port: src1  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: src2  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: ALU_control  input  4  opcode; captured when start is accepted.
REQ-008 Port: ready  output  1  high when idle and able to accept start.
REQ-009 Port: done  output  1  one-cycle pulse marking valid result/flags.
REQ-010 Port: result  output  WIDTH  operation result.
REQ-011 Port: zero  output  1  high when result equals all zeros.
REQ-012 Port: cout  output  1  carry out of the MSB (ADD/SUB/SLT only, else 0).
REQ-013 Port: overflow  output  1  signed overflow (ADD/SUB only, else 0).

Function
REQ-014 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 1101 NAND, 0111 SLT (signed).
REQ-015 The block SHALL compute one bit per cycle, LSB first, through a one-bit slice with a registered carry.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start&ready; RUN->DONE after bit WIDTH-1; DONE->IDLE unconditionally.
REQ-017 ready SHALL equal 1 exactly in IDLE.
REQ-018 On acceptance the block SHALL capture src1, src2, ALU_control, clear the bit counter, and load carry with 1 for SUB/SLT, 0 otherwise.
REQ-019 SUB and SLT SHALL use src1 + ~src2 + 1 in the slice.
REQ-020 done SHALL assert for exactly one cycle in DONE, WIDTH+1 cycles after the accepting edge.
REQ-021 result, zero, cout, overflow SHALL update only on entry to DONE and hold until the next DONE entry or reset.
REQ-022 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB for ADD/SUB; 0 for all other opcodes.
REQ-023 SLT result SHALL be {WIDTH-1 zeros, MSB_of_difference XOR overflow}; cout reports the subtraction carry, overflow reports 0.
REQ-024 zero SHALL be computed on the final result (including SLT's final result).
REQ-025 Undefined opcodes SHALL complete with normal timing and yield result=0, zero=1, cout=0, overflow=0.
REQ-026 start while not ready SHALL be ignored with no effect on the operation in progress.
REQ-027 start asserted in the DONE cycle SHALL be ignored; start asserted in the following IDLE cycle SHALL be accepted.
REQ-028 Operand/opcode input changes after acceptance SHALL not affect the running operation.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, ready=1, done=0, result=0, zero=0, cout=0, overflow=0, counter=0, carry=0.
REQ-030 Reset during RUN SHALL abandon the operation; no done pulse SHALL follow for it.
REQ-031 Deassertion of rst_n SHALL take effect at the next rising clk edge; start is accepted no earlier than that edge.

Structure
REQ-032 Opcode constants and the FSM state encoding SHALL reside in a shared package, alu_pkg.
REQ-033 The one-bit compute SHALL be a sub-module, alu_bit_slice (inputs a, b, cin, op; outputs r, co), purely combinational.
REQ-034 The bit counter SHALL be $clog2(WIDTH) bits wide; operands SHALL be shifted right one bit per RUN cycle.

Verification
REQ-035 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow=1, cout=0, zero=0; done exactly 33 cycles after accept.
REQ-036 SUB 0x00000005 - 0x00000005 -> result 0, zero=1, cout=1, overflow=0.
REQ-037 SLT 0xFFFFFFFF vs 0x00000001 -> result 0x00000001; SLT 0x00000001 vs 0xFFFFFFFF -> result 0.
REQ-038 NOR 0x0 with 0x0 -> 0xFFFFFFFF, zero=0; NAND 0xFFFFFFFF with 0xFFFFFFFF -> 0, zero=1.
REQ-039 Start ADD, assert start with new operands at bit 10 -> ignored; result matches first operands only; single done pulse.
REQ-040 Start SUB, pull rst_n low at bit 16 -> outputs zero, ready=1 immediately, no done; fresh ADD 2+3 afterwards -> result 5.
